// File: rtl/adat_tx_framer_if.sv
// ---------------------------------------------------------------------------
// adat_tx_framer_if
// Sample source handshake for the ADAT transmit framer.
//
// Signals:
//   sample_i [191:0]  eight 24-bit channel samples, channel n at [24n+23:24n]
//   user_i   [3:0]    ADAT user bits for the frame
//   valid_i           sample_i/user_i valid
//   ready_o           framer holding register empty; transfer on valid && ready
//
// Modports:
//   master  sample source (drives payload and valid, observes ready)
//   slave   framer side (observes payload and valid, drives ready)
// ---------------------------------------------------------------------------
interface adat_tx_framer_if;
    logic [191:0] sample_i;
    logic [3:0]   user_i;
    logic         valid_i;
    logic         ready_o;

    modport master (
        output sample_i,
        output user_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  sample_i,
        input  user_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/adat_tx_framer.sv
// ---------------------------------------------------------------------------
// adat_tx_framer
// Serialises one ADAT frame (8 x 24-bit samples + 4 user bits) into a
// 256-bit NRZ bitstream, one bit per bit_en_i strobe. Samples enter through
// a one-entry holding register; frames run back to back across source
// stalls, falling back to a zero or repeated payload when the holding
// register is empty at a frame boundary.
//
// Parameters:
//   IDLE_MODE  0: empty holding at a boundary sends zero samples, user 0000
//              1: empty holding at a boundary repeats the previous payload
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   bit_en_i       bit strobe; one output bit advanced per asserted cycle
//   src            sample source handshake (adat_tx_framer_if.slave)
//   data_o         NRZ frame bit (registered)
//   data_valid_o   data_o meaningful (high while running)
//   frame_start_o  one-cycle pulse alongside bit 0 of each frame
//   underrun_o     one-cycle pulse when a frame starts with holding empty
// ---------------------------------------------------------------------------
module adat_tx_framer #(
    parameter int IDLE_MODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              bit_en_i,
    adat_tx_framer_if.slave   src,
    output logic              data_o,
    output logic              data_valid_o,
    output logic              frame_start_o,
    output logic              underrun_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Frame bit k lives at f[255-k], so the serialiser always emits the MSB.
    function automatic logic [255:0] build_frame(input logic [191:0] s,
                                                 input logic [3:0]   u);
        logic [255:0] f;
        f        = '0;
        f[255]   = 1'b1;
        f[244]   = 1'b1;
        f[243:240] = u;
        for (int j = 0; j < 48; j++) begin
            f[239 - 5*j -: 5] = {1'b1, s[24*(j/6) + 23 - 4*(j%6) -: 4]};
        end
        return f;
    endfunction

    logic [0:0]   state_q,       state_d;
    logic [7:0]   cnt_q,         cnt_d;
    logic [255:0] shift_q,       shift_d;
    logic         hold_full_q,   hold_full_d;
    logic [191:0] hold_sample_q, hold_sample_d;
    logic [3:0]   hold_user_q,   hold_user_d;
    logic [191:0] last_sample_q, last_sample_d;
    logic [3:0]   last_user_q,   last_user_d;
    logic         ready_q,       ready_d;
    logic         data_q,        data_d;
    logic         dv_q,          dv_d;
    logic         fs_q,          fs_d;
    logic         ur_q,          ur_d;

    logic         accept_s;
    logic         load_s;
    logic [191:0] sel_sample_s;
    logic [3:0]   sel_user_s;
    logic [255:0] frame_s;

    // Next-state logic: holding handshake, frame loading and bit serialisation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        hold_full_d   = hold_full_q;
        hold_sample_d = hold_sample_q;
        hold_user_d   = hold_user_q;
        last_sample_d = last_sample_q;
        last_user_d   = last_user_q;
        data_d        = data_q;
        dv_d          = dv_q;
        fs_d          = 1'b0;
        ur_d          = 1'b0;
        load_s        = 1'b0;

        // ready_q is a pure register, so acceptance never depends
        // combinationally on valid_i feeding back into ready_o.
        accept_s = src.valid_i && ready_q;

        if (hold_full_q) begin
            sel_sample_s = hold_sample_q;
            sel_user_s   = hold_user_q;
        end else if (IDLE_MODE != 0) begin
            sel_sample_s = last_sample_q;
            sel_user_s   = last_user_q;
        end else begin
            sel_sample_s = 192'd0;
            sel_user_s   = 4'd0;
        end
        frame_s = build_frame(sel_sample_s, sel_user_s);

        if (bit_en_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        load_s = 1'b1;
                    end else begin
                        data_d = 1'b0;
                        dv_d   = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == 8'd255) begin
                        load_s = 1'b1;
                    end else begin
                        data_d  = shift_q[255];
                        shift_d = {shift_q[254:0], 1'b0};
                        cnt_d   = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    data_d  = 1'b0;
                    dv_d    = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Frame boundary: latch the payload, emit bit 0 and free the holding.
        if (load_s) begin
            data_d        = frame_s[255];
            shift_d       = {frame_s[254:0], 1'b0};
            cnt_d         = 8'd0;
            state_d       = ST_RUN;
            dv_d          = 1'b1;
            fs_d          = 1'b1;
            ur_d          = !hold_full_q;
            last_sample_d = sel_sample_s;
            last_user_d   = sel_user_s;
            hold_full_d   = 1'b0;
        end else begin
            fs_d = 1'b0;
        end

        // Accept only while ready_q is high, which implies holding empty,
        // so a transfer can never coincide with a drain.
        if (accept_s) begin
            hold_full_d   = 1'b1;
            hold_sample_d = src.sample_i;
            hold_user_d   = src.user_i;
        end else begin
            hold_sample_d = hold_sample_d;
        end

        ready_d = !hold_full_d;
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            shift_q       <= 256'd0;
            hold_full_q   <= 1'b0;
            hold_sample_q <= 192'd0;
            hold_user_q   <= 4'd0;
            last_sample_q <= 192'd0;
            last_user_q   <= 4'd0;
            ready_q       <= 1'b0;
            data_q        <= 1'b0;
            dv_q          <= 1'b0;
            fs_q          <= 1'b0;
            ur_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            hold_full_q   <= hold_full_d;
            hold_sample_q <= hold_sample_d;
            hold_user_q   <= hold_user_d;
            last_sample_q <= last_sample_d;
            last_user_q   <= last_user_d;
            ready_q       <= ready_d;
            data_q        <= data_d;
            dv_q          <= dv_d;
            fs_q          <= fs_d;
            ur_q          <= ur_d;
        end
    end

    assign src.ready_o   = ready_q;
    assign data_o        = data_q;
    assign data_valid_o  = dv_q;
    assign frame_start_o = fs_q;
    assign underrun_o    = ur_q;

endmodule

// File: tb/tb_adat_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_adat_tx_framer
// Directed bench for adat_tx_framer. Two instances share one stimulus
// stream: dut0 with IDLE_MODE=0 and dut1 with IDLE_MODE=1. Expected frame
// bits come from a per-bit model of the ADAT frame layout.
// ---------------------------------------------------------------------------
module tb_adat_tx_framer;

    logic clk;
    logic rst_n;
    logic bit_en;

    logic d0, dv0, fs0, ur0;
    logic d1, dv1, fs1, ur1;

    int checks = 0;
    int errors = 0;

    logic got0 [256];
    logic got1 [256];

    adat_tx_framer_if if0 ();
    adat_tx_framer_if if1 ();

    assign if1.sample_i = if0.sample_i;
    assign if1.user_i   = if0.user_i;
    assign if1.valid_i  = if0.valid_i;

    adat_tx_framer #(.IDLE_MODE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bit_en_i(bit_en), .src(if0.slave),
        .data_o(d0), .data_valid_o(dv0), .frame_start_o(fs0), .underrun_o(ur0)
    );

    adat_tx_framer #(.IDLE_MODE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bit_en_i(bit_en), .src(if1.slave),
        .data_o(d1), .data_valid_o(dv1), .frame_start_o(fs1), .underrun_o(ur1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic en);
        bit_en = en;
        @(posedge clk);
        #1;
    endtask

    // Reference for frame bit k, written directly from the frame layout.
    function automatic logic exp_bit(input int k, input logic [191:0] s, input logic [3:0] u);
        int j, p, ch, bp;
        if (k == 0) return 1'b1;
        if (k <= 10) return 1'b0;
        if (k == 11) return 1'b1;
        if (k <= 15) return u[15-k];
        j = (k - 16) / 5;
        p = (k - 16) % 5;
        if (p == 0) return 1'b1;
        ch = j / 6;
        bp = 24*ch + 23 - 4*(j % 6) - (p - 1);
        return s[bp];
    endfunction

    // Runs strobes k = 0..stop_k-1 of one frame, comparing both DUTs.
    task automatic run_frame(input string tag, input int period, input int stop_k,
                             input logic [191:0] e0s, input logic [3:0] e0u,
                             input logic [191:0] e1s, input logic [3:0] e1u,
                             input logic exp_unr,
                             input int off1_k, input logic [191:0] off1_s, input logic [3:0] off1_u,
                             input int off2_k, input logic [191:0] off2_s, input logic [3:0] off2_u,
                             input int stall_k, input int stall_len);
        int bad0 = 0, bad1 = 0, fs_bad = 0, ur_bad = 0, dv_bad = 0, st_bad = 0, rd_bad = 0;
        int idle;
        for (int k = 0; k < stop_k; k++) begin
            idle = period - 1 + ((k == stall_k) ? stall_len : 0);
            for (int i = 0; i < idle; i++) begin
                tick(1'b0);
                if (k > 0) begin
                    if (d0 !== got0[k-1] || d1 !== got1[k-1]) st_bad++;
                    if (dv0 !== 1'b1 || dv1 !== 1'b1) dv_bad++;
                    if (fs0 !== 1'b0 || fs1 !== 1'b0) fs_bad++;
                    if (ur0 !== 1'b0 || ur1 !== 1'b0) ur_bad++;
                end
            end
            if (k == off1_k) begin
                if0.sample_i = off1_s;
                if0.user_i   = off1_u;
                if0.valid_i  = 1'b1;
            end
            if (k == off2_k) begin
                chk({tag, "_ready_low_before_2nd"}, 256'(if0.ready_o), 256'd0);
                if0.sample_i = off2_s;
                if0.user_i   = off2_u;
                if0.valid_i  = 1'b1;
            end
            tick(1'b1);
            if0.valid_i = 1'b0;
            if (k == off1_k) chk({tag, "_ready_drop_accept"}, 256'(if0.ready_o), 256'd0);
            if (k == 0) chk({tag, "_ready_after_boundary"}, 256'(if0.ready_o), 256'd1);
            if (off1_k >= 0 && k > off1_k && if0.ready_o !== 1'b0) rd_bad++;
            got0[k] = d0;
            got1[k] = d1;
            if (d0 !== exp_bit(k, e0s, e0u)) bad0++;
            if (d1 !== exp_bit(k, e1s, e1u)) bad1++;
            if (fs0 !== (k == 0) || fs1 !== (k == 0)) fs_bad++;
            if (ur0 !== (k == 0 && exp_unr) || ur1 !== (k == 0 && exp_unr)) ur_bad++;
            if (dv0 !== 1'b1 || dv1 !== 1'b1) dv_bad++;
        end
        chk({tag, "_bits_mode0"}, 256'(bad0), 256'd0);
        chk({tag, "_bits_mode1"}, 256'(bad1), 256'd0);
        chk({tag, "_frame_start"}, 256'(fs_bad), 256'd0);
        chk({tag, "_underrun"}, 256'(ur_bad), 256'd0);
        chk({tag, "_data_valid"}, 256'(dv_bad), 256'd0);
        if (period > 1 || stall_k >= 0) chk({tag, "_stable_no_strobe"}, 256'(st_bad), 256'd0);
        if (off1_k >= 0) chk({tag, "_ready_held_low"}, 256'(rd_bad), 256'd0);
    endtask

    logic [191:0] p1, p2, p3, p4, p5, p6, p7;
    logic [15:0]  w16;
    logic [29:0]  w30;
    logic [4:0]   w5;
    int cnt_dv, cnt_fs, cnt_ur;

    initial begin
        for (int n = 0; n < 8; n++) p1[24*n +: 24] = 24'(n + 1);
        p2 = {24'h89ABCD, 24'h456789, 24'h0123FE, 24'hDEAD01, 24'hBEEF23, 24'hC0FFEE, 24'h5A5A5A, 24'hA5A5A5};
        p3 = {24'h000000, 24'hFFFFFF, 24'h0F0F0F, 24'hF0F0F0, 24'h123456, 24'h654321, 24'h7E7E7E, 24'h818181};
        p4 = {24'h13579B, 24'h2468AC, 24'hFEDCBA, 24'h987654, 24'h000001, 24'h800000, 24'h3C3C3C, 24'hC3C3C3};
        p5 = {24'h00000F, 24'hAAAAAA, 24'h555555, 24'h102030, 24'h405060, 24'h708090, 24'hABCDEF, 24'hFFFFFF};
        p6 = {24'h0A0B0C, 24'h1D2E3F, 24'h908070, 24'h665544, 24'h332211, 24'hF1E2D3, 24'h777777, 24'h246813};
        p7 = ~p6;

        rst_n = 1'b0;
        bit_en = 1'b0;
        if0.sample_i = 192'd0;
        if0.user_i = 4'd0;
        if0.valid_i = 1'b0;

        // Reset values
        #23;
        chk("rst_data", 256'({d0, d1}), 256'd0);
        chk("rst_valid", 256'({dv0, dv1}), 256'd0);
        chk("rst_pulses", 256'({fs0, fs1, ur0, ur1}), 256'd0);
        chk("rst_ready", 256'({if0.ready_o, if1.ready_o}), 256'd0);
        #4 rst_n = 1'b1;
        tick(1'b0);
        chk("ready_after_rst", 256'({if0.ready_o, if1.ready_o}), 256'd3);

        // Test 1: single transfer, bit_en every cycle
        if0.sample_i = p1;
        if0.user_i = 4'hA;
        if0.valid_i = 1'b1;
        tick(1'b0);
        if0.valid_i = 1'b0;
        chk("t1_ready_drop", 256'(if0.ready_o), 256'd0);
        chk("t1_idle_valid", 256'({dv0, dv1}), 256'd0);
        run_frame("f1", 1, 256, p1, 4'hA, p1, 4'hA, 1'b0,
                  -1, 192'd0, 4'd0, -1, 192'd0, 4'd0, -1, 0);
        for (int k = 0; k < 16; k++) w16[15-k] = got0[k];
        for (int k = 0; k < 30; k++) w30[29-k] = got0[16+k];
        for (int k = 0; k < 5; k++) w5[4-k] = got0[251+k];
        chk("t1_header", 256'(w16), 256'(16'b1000000000011010));
        chk("t1_ch0", 256'(w30), 256'(30'b100001000010000100001000010001));
        chk("t1_ch7_last", 256'(w5), 256'(5'b11000));

        // Test 2: steady stream, 1-in-1 then 1-in-3
        if0.sample_i = p2;
        if0.user_i = 4'h3;
        if0.valid_i = 1'b1;
        tick(1'b0);
        if0.valid_i = 1'b0;
        chk("t2_ready_drop", 256'(if0.ready_o), 256'd0);
        run_frame("f2", 1, 256, p2, 4'h3, p2, 4'h3, 1'b0,
                  100, p3, 4'hC, -1, 192'd0, 4'd0, -1, 0);
        run_frame("f3", 3, 256, p3, 4'hC, p3, 4'hC, 1'b0,
                  60, p4, 4'h9, -1, 192'd0, 4'd0, -1, 0);
        run_frame("f4", 3, 256, p4, 4'h9, p4, 4'h9, 1'b0,
                  200, p5, 4'h6, -1, 192'd0, 4'd0, -1, 0);

        // Test 3: stall after a frame with ch0 = FFFFFF
        run_frame("f5", 1, 256, p5, 4'h6, p5, 4'h6, 1'b0,
                  -1, 192'd0, 4'd0, -1, 192'd0, 4'd0, -1, 0);

        // Test 3 underrun frame, with test 4 mid-frame offers
        run_frame("f6", 1, 256, 192'd0, 4'd0, p5, 4'h6, 1'b1,
                  100, p6, 4'hE, 150, p7, 4'h1, -1, 0);

        // Test 6: bit_en low for 50 cycles mid-frame
        run_frame("f7", 1, 256, p6, 4'hE, p6, 4'hE, 1'b0,
                  -1, 192'd0, 4'd0, -1, 192'd0, 4'd0, 120, 50);

        // Test 5: reset at bit 100 of an underrun frame
        run_frame("f8", 1, 100, 192'd0, 4'd0, p6, 4'hE, 1'b1,
                  -1, 192'd0, 4'd0, -1, 192'd0, 4'd0, -1, 0);
        tick(1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 256'({dv0, dv1}), 256'd0);
        chk("t5_async_data", 256'({d0, d1}), 256'd0);
        chk("t5_async_ready", 256'({if0.ready_o, if1.ready_o}), 256'd0);
        #2 rst_n = 1'b1;
        cnt_dv = 0;
        cnt_fs = 0;
        cnt_ur = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b1);
            if (dv0 !== 1'b0 || dv1 !== 1'b0) cnt_dv++;
            if (fs0 !== 1'b0 || fs1 !== 1'b0) cnt_fs++;
            if (ur0 !== 1'b0 || ur1 !== 1'b0) cnt_ur++;
        end
        chk("t5_idle_valid", 256'(cnt_dv), 256'd0);
        chk("t5_idle_frame_start", 256'(cnt_fs), 256'd0);
        chk("t5_idle_underrun", 256'(cnt_ur), 256'd0);
        chk("t5_ready_idle", 256'({if0.ready_o, if1.ready_o}), 256'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
